// File: rtl/sha_job_dispatcher.sv
// Job dispatcher for NUM_CORES double-SHA256 cores: splits a nonce range into chunks, issues them
// round-robin, retires them on a cycle budget and reports the first winner or exhaustion.
// Optional build macro DISPATCH_STATS_EN adds the stat_chunks retired-chunk counter port.
module sha_job_dispatcher #(
    parameter int NUM_CORES    = 4,
    parameter int CHUNK_LOG2   = 12,
    parameter int CHUNK_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [511:0]             job_data,
    input  logic [255:0]             job_state,
    input  logic [255:0]             job_target,
    input  logic [31:0]              job_nonce_start,
    input  logic [15:0]              job_chunks,
    output logic [NUM_CORES-1:0]     core_start,
    output logic [32*NUM_CORES-1:0]  core_nonce_base,
    output logic [511:0]             core_data,
    output logic [255:0]             core_state,
    output logic [255:0]             core_target,
    input  logic [NUM_CORES-1:0]     core_found,
    input  logic [32*NUM_CORES-1:0]  core_nonce,
    input  logic [256*NUM_CORES-1:0] core_result,
`ifdef DISPATCH_STATS_EN
    output logic [31:0]              stat_chunks,
`endif
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     res_found,
    output logic [31:0]              res_nonce,
    output logic [255:0]             res_hash
);

    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CW = $clog2(CHUNK_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        REPORT   = 2'd2
    } state_t;

    state_t               state_r, state_next_s;
    logic [NUM_CORES-1:0] busy_r, busy_next_s;
    logic [CW-1:0]        cnt_r [NUM_CORES];
    logic [CW-1:0]        cnt_next_s [NUM_CORES];
    logic [PW-1:0]        rr_ptr_r, rr_ptr_next_s;
    logic [15:0]          next_chunk_r, next_chunk_next_s;
    logic [15:0]          chunks_left_r, chunks_left_next_s;
    logic [31:0]          nonce_start_r;
    logic                 job_ready_r;
    logic                 res_found_r, res_found_next_s;
    logic [31:0]          res_nonce_r, res_nonce_next_s;
    logic [255:0]         res_hash_r, res_hash_next_s;
    logic [511:0]         core_data_r;
    logic [255:0]         core_state_r, core_target_r;

    logic [NUM_CORES-1:0] hit_s;
    logic [NUM_CORES-1:0] start_s;
    logic [PW-1:0]        find_idx_s;
    logic                 pick_valid_s;
    logic [PW-1:0]        pick_idx_s;
    logic [PW:0]          rr_sum_s;
    logic [PW:0]          rr_inc_s;
    logic [PW-1:0]        cand_s;
    logic [31:0]          base_s;

    assign hit_s  = (state_r == DISPATCH) ? (core_found & busy_r) : '0;
    assign base_s = nonce_start_r + (32'(next_chunk_r) << CHUNK_LOG2);

    // Lowest-index busy core reporting a winner
    always_comb begin
        find_idx_s = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            find_idx_s = hit_s[i] ? PW'(i) : find_idx_s;
        end
    end

    // First idle core at or after rr_ptr, wrapping
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        rr_sum_s     = '0;
        cand_s       = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            rr_sum_s     = {1'b0, rr_ptr_r} + (PW+1)'(k);
            cand_s       = (rr_sum_s >= (PW+1)'(NUM_CORES)) ? PW'(rr_sum_s - (PW+1)'(NUM_CORES))
                                                            : PW'(rr_sum_s);
            pick_valid_s = pick_valid_s | ~busy_r[cand_s];
            pick_idx_s   = busy_r[cand_s] ? pick_idx_s : cand_s;
        end
        rr_inc_s = {1'b0, pick_idx_s} + (PW+1)'(1);
    end

    // Next-state, bookkeeping and issue decision
    always_comb begin
        state_next_s       = state_r;
        busy_next_s        = busy_r;
        cnt_next_s         = cnt_r;
        rr_ptr_next_s      = rr_ptr_r;
        next_chunk_next_s  = next_chunk_r;
        chunks_left_next_s = chunks_left_r;
        res_found_next_s   = res_found_r;
        res_nonce_next_s   = res_nonce_r;
        res_hash_next_s    = res_hash_r;
        start_s            = '0;
        case (state_r)
            IDLE: begin
                if (job_valid) begin
                    next_chunk_next_s  = 16'd0;
                    chunks_left_next_s = job_chunks;
                    busy_next_s        = '0;
                    if (job_chunks == 16'd0) begin
                        state_next_s     = REPORT;
                        res_found_next_s = 1'b0;
                        res_nonce_next_s = 32'd0;
                        res_hash_next_s  = 256'd0;
                    end else begin
                        state_next_s = DISPATCH;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            DISPATCH: begin
                if (|hit_s) begin
                    res_found_next_s = 1'b1;
                    res_nonce_next_s = core_nonce[int'(find_idx_s)*32 +: 32];
                    res_hash_next_s  = core_result[int'(find_idx_s)*256 +: 256];
                    busy_next_s      = '0;
                    state_next_s     = REPORT;
                end else begin
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (busy_r[i] && (cnt_r[i] == '0)) begin
                            busy_next_s[i] = 1'b0;
                        end else if (busy_r[i]) begin
                            cnt_next_s[i] = cnt_r[i] - CW'(1);
                        end else begin
                            cnt_next_s[i] = cnt_r[i];
                        end
                    end
                    if ((chunks_left_r != 16'd0) && pick_valid_s) begin
                        start_s[pick_idx_s]     = 1'b1;
                        busy_next_s[pick_idx_s] = 1'b1;
                        cnt_next_s[pick_idx_s]  = CW'(CHUNK_CYCLES - 1);
                        rr_ptr_next_s           = (rr_inc_s >= (PW+1)'(NUM_CORES)) ? '0 : PW'(rr_inc_s);
                        next_chunk_next_s       = next_chunk_r + 16'd1;
                        chunks_left_next_s      = chunks_left_r - 16'd1;
                    end else if ((chunks_left_r == 16'd0) && (busy_r == '0)) begin
                        res_found_next_s = 1'b0;
                        res_nonce_next_s = 32'd0;
                        res_hash_next_s  = 256'd0;
                        state_next_s     = REPORT;
                    end else begin
                        state_next_s = DISPATCH;
                    end
                end
            end
            REPORT: begin
                if (res_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = REPORT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            busy_r        <= '0;
            rr_ptr_r      <= '0;
            next_chunk_r  <= 16'd0;
            chunks_left_r <= 16'd0;
            job_ready_r   <= 1'b0;
            res_found_r   <= 1'b0;
            res_nonce_r   <= 32'd0;
            res_hash_r    <= 256'd0;
            for (int i = 0; i < NUM_CORES; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            state_r       <= state_next_s;
            busy_r        <= busy_next_s;
            cnt_r         <= cnt_next_s;
            rr_ptr_r      <= rr_ptr_next_s;
            next_chunk_r  <= next_chunk_next_s;
            chunks_left_r <= chunks_left_next_s;
            job_ready_r   <= (state_next_s == IDLE);
            res_found_r   <= res_found_next_s;
            res_nonce_r   <= res_nonce_next_s;
            res_hash_r    <= res_hash_next_s;
        end
    end

    // Job parameters captured on acceptance and shared by all cores
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_data_r   <= 512'd0;
            core_state_r  <= 256'd0;
            core_target_r <= 256'd0;
            nonce_start_r <= 32'd0;
        end else if ((state_r == IDLE) && job_valid) begin
            core_data_r   <= job_data;
            core_state_r  <= job_state;
            core_target_r <= job_target;
            nonce_start_r <= job_nonce_start;
        end
    end

    // Chunk base is only meaningful on the lane being started
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_base
        assign core_nonce_base[g*32 +: 32] = start_s[g] ? base_s : 32'd0;
    end

    assign core_start  = start_s;
    assign core_data   = core_data_r;
    assign core_state  = core_state_r;
    assign core_target = core_target_r;
    assign job_ready   = job_ready_r;
    assign res_valid   = (state_r == REPORT);
    assign res_found   = res_found_r;
    assign res_nonce   = res_nonce_r;
    assign res_hash    = res_hash_r;

`ifdef DISPATCH_STATS_EN
    logic [31:0] stat_r;
    logic [4:0]  expire_cnt_s;
    logic [32:0] stat_sum_s;

    // Chunks retired by budget expiry this cycle (a find in the same cycle takes precedence)
    always_comb begin
        expire_cnt_s = 5'd0;
        for (int i = 0; i < NUM_CORES; i++) begin
            expire_cnt_s = expire_cnt_s + {4'd0, (state_r == DISPATCH) && (hit_s == '0) &&
                                                 busy_r[i] && (cnt_r[i] == '0)};
        end
        stat_sum_s = {1'b0, stat_r} + 33'(expire_cnt_s);
    end

    // Saturating retired-chunk counter, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_r <= 32'd0;
        end else begin
            stat_r <= stat_sum_s[32] ? 32'hFFFF_FFFF : stat_sum_s[31:0];
        end
    end

    assign stat_chunks = stat_r;
`endif

endmodule

// File: tb/tb_sha_job_dispatcher.sv
// Directed bench for sha_job_dispatcher (4 cores, 4096-nonce chunks, 8-cycle budget).
module tb_sha_job_dispatcher;

    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic [511:0]  job_data = '0;
    logic [255:0]  job_state = '0;
    logic [255:0]  job_target = '0;
    logic [31:0]   job_nonce_start = '0;
    logic [15:0]   job_chunks = '0;
    logic [NC-1:0] core_start;
    logic [32*NC-1:0]  core_nonce_base;
    logic [511:0]  core_data;
    logic [255:0]  core_state;
    logic [255:0]  core_target;
    logic [NC-1:0] core_found = '0;
    logic [32*NC-1:0]  core_nonce = '0;
    logic [256*NC-1:0] core_result = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          res_found;
    logic [31:0]   res_nonce;
    logic [255:0]  res_hash;
`ifdef DISPATCH_STATS_EN
    logic [31:0]   stat_chunks;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sha_job_dispatcher #(.NUM_CORES(NC), .CHUNK_LOG2(12), .CHUNK_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_data(job_data), .job_state(job_state), .job_target(job_target),
        .job_nonce_start(job_nonce_start), .job_chunks(job_chunks),
        .core_start(core_start), .core_nonce_base(core_nonce_base),
        .core_data(core_data), .core_state(core_state), .core_target(core_target),
        .core_found(core_found), .core_nonce(core_nonce), .core_result(core_result),
`ifdef DISPATCH_STATS_EN
        .stat_chunks(stat_chunks),
`endif
        .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found),
        .res_nonce(res_nonce), .res_hash(res_hash)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        core_found = '0;
        res_ready = 1'b0;
        job_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_job(input logic [15:0] ch, input logic [31:0] st, input logic [511:0] d);
        job_valid       = 1'b1;
        job_chunks      = ch;
        job_nonce_start = st;
        job_data        = d;
        job_state       = {8{32'h6A09_E667}};
        job_target      = {32'h0000_FFFF, 224'd0};
        tick();
        job_valid = 1'b0;
    endtask

    logic [3:0]   es;
    logic [31:0]  eb;
    logic [255:0] h1, h2, h3;

    initial begin
        h1 = {8{32'h1111_AAAA}};
        h2 = {8{32'h2222_BBBB}};
        h3 = {8{32'h3333_CCCC}};

        // Reset state
        #3;
        chk("rst_job_ready", job_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_data", core_data, 0);
        tick();
        rst = 1'b0;
        tick();
        #2;
        chk("post_rst_job_ready", job_ready, 1);

        // Empty job goes straight to an exhausted result
        start_job(16'd0, 32'h55, {16{32'hCAFE_F00D}});
        #2;
        chk("empty_core_start", core_start, 0);
        chk("empty_res_valid", res_valid, 1);
        chk("empty_res_found", res_found, 0);
        chk("empty_res_nonce", res_nonce, 0);
        chk("empty_job_ready", job_ready, 0);
        chk("empty_core_data", core_data, {16{32'hCAFE_F00D}});
        chk("empty_core_state", core_state, {8{32'h6A09_E667}});
        res_ready = 1'b1;
        tick();
        #2;
        chk("empty_done_valid", res_valid, 0);
        chk("empty_done_ready", job_ready, 1);
        res_ready = 1'b0;

        // Exhaustion: 6 chunks over 4 cores, restart after the 8-cycle budget
        start_job(16'd6, 32'h100, {16{32'h0123_4567}});
        for (int d = 0; d <= 20; d++) begin
            if (d != 0) tick();
            #2;
            case (d)
                0:       begin es = 4'b0001; eb = 32'h100;  end
                1:       begin es = 4'b0010; eb = 32'h1100; end
                2:       begin es = 4'b0100; eb = 32'h2100; end
                3:       begin es = 4'b1000; eb = 32'h3100; end
                9:       begin es = 4'b0001; eb = 32'h4100; end
                10:      begin es = 4'b0010; eb = 32'h5100; end
                default: begin es = 4'b0000; eb = 32'h0;    end
            endcase
            chk($sformatf("exh_start_d%0d", d), core_start, es);
            for (int i = 0; i < NC; i++) begin
                if (es[i]) chk($sformatf("exh_base_d%0d", d), core_nonce_base[i*32 +: 32], eb);
            end
            chk($sformatf("exh_res_valid_d%0d", d), res_valid, (d == 20));
        end
        chk("exh_res_found", res_found, 0);
        chk("exh_res_nonce", res_nonce, 0);
        chk("exh_res_hash", res_hash, 0);
        chk("exh_job_ready", job_ready, 0);
`ifdef DISPATCH_STATS_EN
        chk("exh_stat_chunks", stat_chunks, 6);
`endif
        res_ready = 1'b1;
        tick();
        #2;
        chk("exh_done_ready", job_ready, 1);
        chk("exh_done_valid", res_valid, 0);

        // Find on core 2, with a spurious report from idle core 3 first
        do_reset();
        start_job(16'd6, 32'h0, {16{32'h89AB_CDEF}});
        #2;
        chk("find_start_d0", core_start, 4'b0001);
        tick();
        core_found = 4'b1000;
        core_nonce[3*32 +: 32] = 32'hDEAD;
        core_result[3*256 +: 256] = h3;
        #2;
        chk("find_ignore_idle", core_start, 4'b0010);
        chk("find_base_d1", core_nonce_base[1*32 +: 32], 32'h1000);
        tick();
        core_found = '0;
        #2;
        chk("find_start_d2", core_start, 4'b0100);
        tick();
        core_found = 4'b0100;
        core_nonce[2*32 +: 32] = 32'h2155;
        core_result[2*256 +: 256] = h2;
        #2;
        chk("find_blocks_issue", core_start, 4'b0000);
        tick();
        core_found = '0;
        #2;
        chk("find_res_valid", res_valid, 1);
        chk("find_res_found", res_found, 1);
        chk("find_res_nonce", res_nonce, 32'h2155);
        chk("find_res_hash", res_hash, h2);
        chk("find_no_start", core_start, 0);
        for (int c = 0; c < 10; c++) begin
            tick();
            #2;
            chk("bp_res_valid", res_valid, 1);
            chk("bp_res_nonce", res_nonce, 32'h2155);
            chk("bp_res_hash", res_hash, h2);
            chk("bp_job_ready", job_ready, 0);
        end
        res_ready = 1'b1;
        tick();
        #2;
        chk("bp_release_ready", job_ready, 1);
        chk("bp_release_valid", res_valid, 0);
        res_ready = 1'b0;

        // Simultaneous finds on cores 1 and 3: lower index wins
        do_reset();
        start_job(16'd6, 32'h10000, {16{32'h0F0F_0F0F}});
        #2;
        chk("sim_start_d0", core_start, 4'b0001);
        tick();
        tick();
        tick();
        tick();
        core_found = 4'b1010;
        core_nonce[1*32 +: 32] = 32'h11111;
        core_nonce[3*32 +: 32] = 32'h33333;
        core_result[1*256 +: 256] = h1;
        core_result[3*256 +: 256] = h3;
        #2;
        chk("sim_all_busy", core_start, 0);
        tick();
        core_found = '0;
        #2;
        chk("sim_res_found", res_found, 1);
        chk("sim_res_nonce", res_nonce, 32'h11111);
        chk("sim_res_hash", res_hash, h1);
        res_ready = 1'b1;
        tick();
        #2;
        chk("sim_done_ready", job_ready, 1);
        res_ready = 1'b0;

        // Asynchronous reset between clock edges in the middle of dispatch
        start_job(16'd6, 32'h0, {16{32'h7777_1234}});
        #2;
        chk("arst_core_data", core_data, {16{32'h7777_1234}});
        tick();
        #2;
        chk("arst_start_d1", core_start, 4'b0010);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_core_start", core_start, 0);
        chk("arst_base", core_nonce_base, 0);
        chk("arst_job_ready", job_ready, 0);
        chk("arst_res_valid", res_valid, 0);
        chk("arst_core_data0", core_data, 0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            #2;
            chk("arst_after_ready", job_ready, 1);
            chk("arst_after_valid", res_valid, 0);
            chk("arst_after_start", core_start, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha_job_dispatcher.md
Name: sha_job_dispatcher

Overview:
Work scheduler that sits between the host-side job interface and NUM_CORES double-SHA256 mining cores. It accepts one job (header block, midstate, target, nonce range) and splits the range into fixed-size chunks. Chunks are handed to idle cores round-robin, and each core's chunk is retired after a fixed cycle budget. The dispatcher collects the first winning nonce, or reports exhaustion, through a result handshake.

Parameters:
NUM_CORES, 4, number of attached cores (1..16)
CHUNK_LOG2, 12, log2 nonces per chunk; chunk base = job_nonce_start + k<<CHUNK_LOG2
CHUNK_CYCLES, 4096, cycles a core is allowed on one chunk before it is reassigned (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
job_valid  in  1  job offered
job_ready  out  1  dispatcher idle, accepts job
job_data  in  512  header block (64 bytes)
job_state  in  256  midstate (8x32)
job_target  in  256  target; hash < target wins
job_nonce_start  in  32  first nonce
job_chunks  in  16  number of chunks in job (0 = empty job)
core_start  out  NUM_CORES  one-cycle start pulse per core
core_nonce_base  out  32*NUM_CORES  per-core chunk base, valid with core_start
core_data  out  512  registered job_data, shared
core_state  out  256  registered job_state, shared
core_target  out  256  registered job_target, shared
core_found  in  NUM_CORES  per-core valid (core reports winning nonce)
core_nonce  in  32*NUM_CORES  per-core winning nonce
core_result  in  256*NUM_CORES  per-core winning hash
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_found  out  1  1 = winner, 0 = range exhausted
res_nonce  out  32  winning nonce (0 when not found)
res_hash  out  256  winning hash (0 when not found)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst; every flop clears immediately on rst assertion.
- Reset values: all outputs 0, except job_ready=0 during reset and 1 in the first cycle after rst deasserts. FSM enters IDLE.
- FSM states: IDLE, DISPATCH, REPORT.
- IDLE: job_ready=1. On job_valid:
  - Register data, state and target onto the core_* buses.
  - next_chunk=0, chunks_left=job_chunks.
  - Clear all core busy bits; go DISPATCH.
  - If job_chunks=0, go straight to REPORT with res_found=0.
- DISPATCH, per cycle, in this priority order:
  1. Find. Any core_found bit set on a busy core: latch the lowest-index such core's nonce and hash. Set res_found=1, clear all busy bits, issue no further core_start, go REPORT. core_found from non-busy cores is ignored.
  2. Retire. Each busy core has a down-counter loaded with CHUNK_CYCLES-1 at start. When it reaches 0, the busy bit clears in the next cycle. A find and an expiry in the same cycle count as a find.
  3. Issue. If chunks_left>0 and some core is idle, pulse core_start for exactly one idle core:
     - Pick the first idle core at or after rr_ptr (wrapping); rr_ptr then advances to that core+1 mod NUM_CORES.
     - Drive core_nonce_base = job_nonce_start + (next_chunk<<CHUNK_LOG2), 32-bit wrap allowed.
     - Increment next_chunk, decrement chunks_left. Maximum one issue per cycle.
  4. Exhaust. When chunks_left=0 and no core is busy: res_found=0, go REPORT.
- Latency: the first core_start fires the cycle after job acceptance. Throughput is one chunk issued per cycle.
- core_start timing: a core may be restarted in the cycle its busy bit clears at the earliest. It is never pulsed while that core is busy.
- REPORT: res_valid=1, res_* held stable until res_valid&&res_ready. On that handshake go IDLE, res_valid=0 next cycle.
- job_valid outside IDLE is ignored (job_ready=0).
- Reset mid-job: all state is discarded immediately, no result is emitted, and core_start is held 0.
- core_data, core_state and core_target hold their values until the next job is accepted.

Optional Feature:
Macro DISPATCH_STATS_EN.
- Defined: adds output port stat_chunks (32 bits), counting chunks fully retired by budget expiry since reset. It saturates at all-ones, is cleared by rst only, and is not cleared per job.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Empty job: job_chunks=0 accepted -> no core_start; next cycle res_valid=1, res_found=0, res_nonce=0.
- Exhaustion, NUM_CORES=4, CHUNK_CYCLES=8, job_chunks=6, start=0x100, no finds -> core_start pulses cores 0,1,2,3 on consecutive cycles with bases 0x100, 0x1100, 0x2100, 0x3100. After expiry, cores 0,1 get 0x4100, 0x5100; then res_found=0.
- Find: core 2 asserts core_found with nonce 0x2155 -> res_found=1, res_nonce=0x2155, res_hash = core 2's result, no further core_start.
- Simultaneous finds on cores 1 and 3 in the same cycle -> core 1's nonce reported.
- Backpressure: res_ready=0 for 10 cycles in REPORT -> res_* stable, job_ready=0; then res_ready=1 -> job_ready=1 next cycle.
- Async reset asserted mid-DISPATCH, between clock edges -> outputs 0 immediately; after release job_ready=1 and no res_valid.
